raster_tile_scheduler: RTL and testbench
========================================

// Module: raster_tile_scheduler
// PURPOSE
//  Bins each incoming screen-space triangle to the tiles its bounding box covers. Issues one
//  (triangle, tile_x, tile_y) job per covered tile, in row-major order, to the raster pipeline's
//  vld_in/rdy_in port. Sits between triangle setup and raster; raster sees one tile job per handshake.
// PARAMETERS
//  FX_W         16  signed fixed-point vertex coordinate width
//  FRAC_W       4   fractional bits of vertex coordinates
//  TILE_W_LOG2  3   tile width in pixels = 2**TILE_W_LOG2
//  TILE_H_LOG2  3   tile height in pixels = 2**TILE_H_LOG2
//  TCOL_W       4   tile column index width; screen = 2**TCOL_W tiles wide
//  TROW_W       4   tile row index width; screen = 2**TROW_W tiles high
//  COLOR_W      8   colour width
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active-high
//  s_vld       in   1        triangle valid
//  s_rdy       out  1        triangle accepted when s_vld&&s_rdy
//  s_v{0,1,2}_{x,y,z} in FX_W  vertices, signed fixed-point
//  s_color     in   COLOR_W  triangle colour
//  m_vld       out  1        tile job valid (to raster vld_in)
//  m_rdy       in   1        raster ready (from raster rdy_in)
//  m_v{0,1,2}_{x,y,z} out FX_W  registered copy of accepted vertices
//  m_color     out  COLOR_W  registered colour
//  m_tile_x    out  TCOL_W   tile column of current job
//  m_tile_y    out  TROW_W   tile row of current job
//  busy        out  1        high in any state other than IDLE
//  tiles_issued out 32       count of m handshakes, saturates at 2**32-1
//  tris_culled  out 16       count of culled triangles, saturates
// BEHAVIOUR
//  Reset: state=IDLE; s_rdy=1, m_vld=0, busy=0, counters=0; m_* data and tile=0.
//  FSM IDLE -> BBOX -> ISSUE -> IDLE.
//   IDLE:  s_rdy=1. On s_vld: register vertices and colour; go to BBOX.
//   BBOX:  s_rdy=0, m_vld=0. Compute and register the tile range; go to ISSUE.
//          If culled, increment tris_culled and go to IDLE.
//   ISSUE: m_vld=1. On m_vld&&m_rdy: if tile_x<tx_max then tile_x++;
//          else if tile_y<ty_max then tile_x=tx_min, tile_y++;
//          else go to IDLE (m_vld=0, s_rdy=1 the next cycle).
//  Bounding box:
//   - px = v>>>FRAC_W (arithmetic shift, floor); xmin/xmax/ymin/ymax over the 3 vertices.
//   - Culled if xmax<0, ymax<0, xmin>SCR_W-1 or ymin>SCR_H-1,
//     where SCR_W=2**(TCOL_W+TILE_W_LOG2) and SCR_H=2**(TROW_W+TILE_H_LOG2).
//   - Otherwise clamp to [0,SCR-1]; tx = px>>TILE_W_LOG2, ty = py>>TILE_H_LOG2.
//   - Degenerate (zero-area) triangles are not culled; their bbox is issued.
//  Latency: accept at cycle N -> first m_vld at N+2. One tile per cycle when m_rdy is held high.
//  Tile count = (tx_max-tx_min+1)*(ty_max-ty_min+1). The last tile's handshake ends the triangle.
//  Stall: while m_vld&&!m_rdy, all m_* outputs are held stable.
//  No wrap: comparisons happen before increment, so index 2**TCOL_W-1 never overflows to 0.
//  Reset mid-ISSUE or mid-BBOX: the triangle is dropped. m_vld=0 and s_rdy=1 on the cycle after rst.
//  s_vld is ignored outside IDLE; no triangle is buffered or lost.
//  Arithmetic: bbox compare in FX_W signed; tile indices unsigned after clamp.
// STRUCTURE
//  raster_pkg: fx_t (signed FX_W), vertex_t struct {x,y,z}, tile_idx_t, sched_state_e enum.
//  Sub-module bbox_tile_range (combinational): 3 vertices -> {culled, tx_min, tx_max, ty_min, ty_max};
//  its outputs are registered in BBOX. FSM, iterators and counters are in this module.
// TESTING (FRAC_W=4, 8x8 tiles, 16x16 tiles, 128x128 screen; coordinates given in pixels, x16)
//  1 verts (1,1),(20,2),(3,12), m_rdy=1
//    -> 6 jobs in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); first m_vld at N+2; tiles_issued=6.
//  2 verts (-5,3),(-3,4),(-1,9)
//    -> no m_vld; tris_culled=1; s_rdy back high 2 cycles after accept.
//  3 verts (-10,-10),(200,5),(60,130)
//    -> clamp gives tx 0..15, ty 0..15; 256 jobs; last job (15,15); no wrap to (0,0).
//  4 case 1 with m_rdy low for 3 cycles on tile (1,0)
//    -> m_tile, m_v*, m_color stable; m_vld held; sequence then resumes unchanged.
//  5 rst asserted during ISSUE at tile (1,0)
//    -> next cycle m_vld=0, s_rdy=1, busy=0, counters=0; new triangle processes normally.
//  6 verts (9,9),(10,9),(9,10) followed back-to-back by case 1 with s_vld held
//    -> 1 job (1,1); second triangle accepted in the cycle after that job's handshake.

Source files
------------

// File: rtl/raster_tile_scheduler_pkg.sv
// raster_pkg: shared widths, screen limits and types for the tile scheduler
package raster_pkg;
  localparam int FX_W = 16;
  localparam int FRAC_W = 4;
  localparam int TILE_W_LOG2 = 3;
  localparam int TILE_H_LOG2 = 3;
  localparam int TCOL_W = 4;
  localparam int TROW_W = 4;
  localparam int COLOR_W = 8;
  localparam int SCR_W = 2 ** (TCOL_W + TILE_W_LOG2);
  localparam int SCR_H = 2 ** (TROW_W + TILE_H_LOG2);
  typedef logic signed [FX_W-1:0] fx_t;
  typedef struct packed {fx_t x; fx_t y; fx_t z;} vertex_t;
  typedef logic [TCOL_W-1:0] tile_idx_t;
  typedef logic [TROW_W-1:0] tile_row_t;
  typedef enum logic [1:0] {IDLE, BBOX, ISSUE} sched_state_e;
  localparam fx_t SCR_X_MAX = fx_t'(SCR_W - 1);
  localparam fx_t SCR_Y_MAX = fx_t'(SCR_H - 1);
  function automatic fx_t min3(fx_t a, fx_t b, fx_t c);
    fx_t m;
    m = a < b ? a : b;
    return m < c ? m : c;
  endfunction
  function automatic fx_t max3(fx_t a, fx_t b, fx_t c);
    fx_t m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/raster_tile_scheduler_bbox.sv
// bbox_tile_range: vertex x/y -> cull flag and clamped tile range of the pixel bounding box
//   in:  x0..x2, y0..y2 signed fixed-point vertex coordinates
//   out: culled, tx_min/tx_max (columns), ty_min/ty_max (rows); range is meaningless when culled
module bbox_tile_range
  import raster_pkg::*;
(
  input  fx_t       x0,
  input  fx_t       y0,
  input  fx_t       x1,
  input  fx_t       y1,
  input  fx_t       x2,
  input  fx_t       y2,
  output logic      culled,
  output tile_idx_t tx_min,
  output tile_idx_t tx_max,
  output tile_row_t ty_min,
  output tile_row_t ty_max
);
  fx_t xmin, xmax, ymin, ymax, cx0, cx1, cy0, cy1;
  always_comb begin
    xmin = min3(x0 >>> FRAC_W, x1 >>> FRAC_W, x2 >>> FRAC_W);
    xmax = max3(x0 >>> FRAC_W, x1 >>> FRAC_W, x2 >>> FRAC_W);
    ymin = min3(y0 >>> FRAC_W, y1 >>> FRAC_W, y2 >>> FRAC_W);
    ymax = max3(y0 >>> FRAC_W, y1 >>> FRAC_W, y2 >>> FRAC_W);
    culled = xmax < 0 || ymax < 0 || xmin > SCR_X_MAX || ymin > SCR_Y_MAX;
    cx0 = xmin < 0 ? '0 : xmin;
    cx1 = xmax > SCR_X_MAX ? SCR_X_MAX : xmax;
    cy0 = ymin < 0 ? '0 : ymin;
    cy1 = ymax > SCR_Y_MAX ? SCR_Y_MAX : ymax;
    tx_min = tile_idx_t'(cx0 >>> TILE_W_LOG2);
    tx_max = tile_idx_t'(cx1 >>> TILE_W_LOG2);
    ty_min = tile_row_t'(cy0 >>> TILE_H_LOG2);
    ty_max = tile_row_t'(cy1 >>> TILE_H_LOG2);
  end
endmodule

// File: rtl/raster_tile_scheduler.sv
// raster_tile_scheduler: bins accepted triangles into row-major tile jobs for the raster stage
//   s_*: triangle input handshake (vertices, colour); m_*: one tile job per handshake with
//   registered vertices/colour and tile indices; busy, tiles_issued, tris_culled: status.
module raster_tile_scheduler
  import raster_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_vld,
  output logic              s_rdy,
  input  logic [FX_W-1:0]   s_v0_x,
  input  logic [FX_W-1:0]   s_v0_y,
  input  logic [FX_W-1:0]   s_v0_z,
  input  logic [FX_W-1:0]   s_v1_x,
  input  logic [FX_W-1:0]   s_v1_y,
  input  logic [FX_W-1:0]   s_v1_z,
  input  logic [FX_W-1:0]   s_v2_x,
  input  logic [FX_W-1:0]   s_v2_y,
  input  logic [FX_W-1:0]   s_v2_z,
  input  logic [COLOR_W-1:0] s_color,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic [FX_W-1:0]   m_v0_x,
  output logic [FX_W-1:0]   m_v0_y,
  output logic [FX_W-1:0]   m_v0_z,
  output logic [FX_W-1:0]   m_v1_x,
  output logic [FX_W-1:0]   m_v1_y,
  output logic [FX_W-1:0]   m_v1_z,
  output logic [FX_W-1:0]   m_v2_x,
  output logic [FX_W-1:0]   m_v2_y,
  output logic [FX_W-1:0]   m_v2_z,
  output logic [COLOR_W-1:0] m_color,
  output logic [TCOL_W-1:0] m_tile_x,
  output logic [TROW_W-1:0] m_tile_y,
  output logic              busy,
  output logic [31:0]       tiles_issued,
  output logic [15:0]       tris_culled
);
  sched_state_e state_q, state_d;
  vertex_t v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [COLOR_W-1:0] color_q, color_d;
  tile_idx_t tx_min_q, tx_min_d, tx_max_q, tx_max_d, tile_x_q, tile_x_d, tx_min, tx_max;
  tile_row_t ty_min_q, ty_min_d, ty_max_q, ty_max_d, tile_y_q, tile_y_d, ty_min, ty_max;
  logic [31:0] tiles_issued_q, tiles_issued_d;
  logic [15:0] tris_culled_q, tris_culled_d;
  logic culled;
  bbox_tile_range u_bbox (
    .x0(v0_q.x), .y0(v0_q.y), .x1(v1_q.x), .y1(v1_q.y), .x2(v2_q.x), .y2(v2_q.y),
    .culled(culled), .tx_min(tx_min), .tx_max(tx_max), .ty_min(ty_min), .ty_max(ty_max)
  );
  always_comb begin
    state_d = state_q;
    v0_d = v0_q;
    v1_d = v1_q;
    v2_d = v2_q;
    color_d = color_q;
    tx_min_d = tx_min_q;
    tx_max_d = tx_max_q;
    ty_min_d = ty_min_q;
    ty_max_d = ty_max_q;
    tile_x_d = tile_x_q;
    tile_y_d = tile_y_q;
    tiles_issued_d = tiles_issued_q;
    tris_culled_d = tris_culled_q;
    s_rdy = state_q == IDLE;
    m_vld = state_q == ISSUE;
    busy = state_q != IDLE;
    if (s_vld && s_rdy) begin
      v0_d = {s_v0_x, s_v0_y, s_v0_z};
      v1_d = {s_v1_x, s_v1_y, s_v1_z};
      v2_d = {s_v2_x, s_v2_y, s_v2_z};
      color_d = s_color;
      state_d = BBOX;
    end
    if (state_q == BBOX) begin
      tx_min_d = tx_min;
      tx_max_d = tx_max;
      ty_min_d = ty_min;
      ty_max_d = ty_max;
      tile_x_d = tx_min;
      tile_y_d = ty_min;
      state_d = culled ? IDLE : ISSUE;
      tris_culled_d = tris_culled_q + 16'(culled && tris_culled_q != '1);
    end
    // compare before increment so the last column/row index never wraps
    if (m_vld && m_rdy) begin
      tiles_issued_d = tiles_issued_q + 32'(tiles_issued_q != '1);
      if (tile_x_q < tx_max_q) tile_x_d = tile_x_q + tile_idx_t'(1);
      else if (tile_y_q < ty_max_q) begin
        tile_x_d = tx_min_q;
        tile_y_d = tile_y_q + tile_row_t'(1);
      end else state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q <= '0;
      v1_q <= '0;
      v2_q <= '0;
      color_q <= '0;
      tx_min_q <= '0;
      tx_max_q <= '0;
      ty_min_q <= '0;
      ty_max_q <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
      tiles_issued_q <= '0;
      tris_culled_q <= '0;
    end else begin
      state_q <= state_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      color_q <= color_d;
      tx_min_q <= tx_min_d;
      tx_max_q <= tx_max_d;
      ty_min_q <= ty_min_d;
      ty_max_q <= ty_max_d;
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
      tiles_issued_q <= tiles_issued_d;
      tris_culled_q <= tris_culled_d;
    end
  end
  assign m_v0_x = v0_q.x;
  assign m_v0_y = v0_q.y;
  assign m_v0_z = v0_q.z;
  assign m_v1_x = v1_q.x;
  assign m_v1_y = v1_q.y;
  assign m_v1_z = v1_q.z;
  assign m_v2_x = v2_q.x;
  assign m_v2_y = v2_q.y;
  assign m_v2_z = v2_q.z;
  assign m_color = color_q;
  assign m_tile_x = tile_x_q;
  assign m_tile_y = tile_y_q;
  assign tiles_issued = tiles_issued_q;
  assign tris_culled = tris_culled_q;
endmodule

// File: tb/tb_raster_tile_scheduler.sv
// tb_raster_tile_scheduler: directed and random triangles checked against a pixel-level tile model
module tb_raster_tile_scheduler;
  logic clk = 0, rst = 1, s_vld = 0, m_rdy = 1;
  logic s_rdy, m_vld, busy;
  logic [15:0] s_v0_x, s_v0_y, s_v0_z, s_v1_x, s_v1_y, s_v1_z, s_v2_x, s_v2_y, s_v2_z;
  logic [15:0] m_v0_x, m_v0_y, m_v0_z, m_v1_x, m_v1_y, m_v1_z, m_v2_x, m_v2_y, m_v2_z;
  logic [7:0] s_color, m_color;
  logic [3:0] m_tile_x, m_tile_y;
  logic [31:0] tiles_issued;
  logic [15:0] tris_culled;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  raster_tile_scheduler dut (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy),
    .s_v0_x(s_v0_x), .s_v0_y(s_v0_y), .s_v0_z(s_v0_z),
    .s_v1_x(s_v1_x), .s_v1_y(s_v1_y), .s_v1_z(s_v1_z),
    .s_v2_x(s_v2_x), .s_v2_y(s_v2_y), .s_v2_z(s_v2_z),
    .s_color(s_color), .m_vld(m_vld), .m_rdy(m_rdy),
    .m_v0_x(m_v0_x), .m_v0_y(m_v0_y), .m_v0_z(m_v0_z),
    .m_v1_x(m_v1_x), .m_v1_y(m_v1_y), .m_v1_z(m_v1_z),
    .m_v2_x(m_v2_x), .m_v2_y(m_v2_y), .m_v2_z(m_v2_z),
    .m_color(m_color), .m_tile_x(m_tile_x), .m_tile_y(m_tile_y),
    .busy(busy), .tiles_issued(tiles_issued), .tris_culled(tris_culled)
  );
  logic [159:0] dout;
  assign dout = {m_v0_x, m_v0_y, m_v0_z, m_v1_x, m_v1_y, m_v1_z, m_v2_x, m_v2_y, m_v2_z,
                 m_color, m_tile_x, m_tile_y};
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {int tx; int ty;} job_t;
  job_t exp_q[$];
  logic [151:0] exp_data;
  int exp_tiles = 0, exp_culled = 0, cyc = 0, acc_cyc = 0, hs_cyc = 0;
  bit last_culled = 0, skip_rise = 1;
  logic pv_m = 0, pv_rdy = 0, pv_s = 0;
  logic [159:0] p_out;
  int rdy_mode = 0, stall_n = 0;
  bit stall_armed = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int floor16(int v);
    return v >= 0 ? v / 16 : -((-v + 15) / 16);
  endfunction
  function automatic int clamp127(int v);
    return v < 0 ? 0 : v > 127 ? 127 : v;
  endfunction
  task automatic model(input int x0, y0, x1, y1, x2, y2);
    int px[3], py[3], xmn, xmx, ymn, ymx;
    px = '{floor16(x0), floor16(x1), floor16(x2)};
    py = '{floor16(y0), floor16(y1), floor16(y2)};
    xmn = px[0]; xmx = px[0]; ymn = py[0]; ymx = py[0];
    for (int i = 1; i < 3; i++) begin
      if (px[i] < xmn) xmn = px[i];
      if (px[i] > xmx) xmx = px[i];
      if (py[i] < ymn) ymn = py[i];
      if (py[i] > ymx) ymx = py[i];
    end
    last_culled = xmx < 0 || ymx < 0 || xmn > 127 || ymn > 127;
    if (last_culled) exp_culled++;
    else
      for (int ty = clamp127(ymn) / 8; ty <= clamp127(ymx) / 8; ty++)
        for (int tx = clamp127(xmn) / 8; tx <= clamp127(xmx) / 8; tx++)
          exp_q.push_back('{tx, ty});
  endtask
  always @(negedge clk) begin
    job_t j;
    if (rst) begin
      exp_q.delete();
      exp_tiles = 0;
      exp_culled = 0;
      skip_rise = 1;
    end else begin
      if (pv_m && !pv_rdy) begin
        check("stall_hold", dout, p_out);
        check("stall_vld", m_vld, 1);
      end
      if (m_vld && !pv_m) check("latency", cyc - acc_cyc, 2);
      if (s_rdy && !pv_s && !skip_rise)
        check("rdy_back", last_culled ? cyc - acc_cyc : cyc - hs_cyc, last_culled ? 2 : 1);
      if (m_vld && m_rdy) begin
        if (exp_q.size() == 0) check("extra_job", exp_q.size(), 1);
        else begin
          j = exp_q.pop_front();
          check("tile", {m_tile_x, m_tile_y}, {4'(j.tx), 4'(j.ty)});
          check("job_data", dout[159:8], exp_data);
        end
        exp_tiles++;
        hs_cyc = cyc;
      end
      if (s_vld && s_rdy) begin
        model(int'($signed(s_v0_x)), int'($signed(s_v0_y)), int'($signed(s_v1_x)),
              int'($signed(s_v1_y)), int'($signed(s_v2_x)), int'($signed(s_v2_y)));
        acc_cyc = cyc;
        exp_data = {s_v0_x, s_v0_y, s_v0_z, s_v1_x, s_v1_y, s_v1_z, s_v2_x, s_v2_y, s_v2_z, s_color};
      end
      skip_rise = 0;
    end
    pv_m = m_vld;
    pv_rdy = m_rdy;
    pv_s = s_rdy;
    p_out = dout;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 2 && stall_armed && m_vld && m_tile_x == 1 && m_tile_y == 0) begin
      stall_n = 3;
      stall_armed = 0;
    end
    m_rdy = rdy_mode == 1 ? ($urandom_range(0, 3) != 0) : stall_n == 0;
    if (stall_n > 0) stall_n--;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int x0, y0, x1, y1, x2, y2, input bit hold);
    int n = 0;
    s_v0_x = 16'(x0); s_v0_y = 16'(y0); s_v0_z = 16'($urandom);
    s_v1_x = 16'(x1); s_v1_y = 16'(y1); s_v1_z = 16'($urandom);
    s_v2_x = 16'(x2); s_v2_y = 16'(y2); s_v2_z = 16'($urandom);
    s_color = 8'($urandom);
    s_vld = 1;
    while (!s_rdy && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("accept_timeout", n, 0);
    tick();
    if (!hold) s_vld = 0;
  endtask
  task automatic send_px(input int x0, y0, x1, y1, x2, y2, input bit hold);
    send(x0 * 16, y0 * 16, x1 * 16, y1 * 16, x2 * 16, y2 * 16, hold);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check({tag, "_timeout"}, n, 0);
    check({tag, "_tiles"}, tiles_issued, exp_tiles);
    check({tag, "_culled"}, tris_culled, exp_culled);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask
  initial begin
    int n, c, h, v[6];
    {s_v0_x, s_v0_y, s_v0_z, s_v1_x, s_v1_y, s_v1_z, s_v2_x, s_v2_y, s_v2_z, s_color} = '0;
    tick();
    tick();
    check("rst_s_rdy", s_rdy, 1);
    check("rst_m_vld", m_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_counters", {tiles_issued, tris_culled}, 0);
    check("rst_data", dout, 0);
    rst = 0;
    send_px(1, 1, 20, 2, 3, 12, 0);
    wait_idle("case1");
    send_px(-5, 3, -3, 4, -1, 9, 0);
    wait_idle("case2");
    send_px(-10, -10, 200, 5, 60, 130, 0);
    wait_idle("case3");
    rdy_mode = 2;
    stall_armed = 1;
    send_px(1, 1, 20, 2, 3, 12, 0);
    wait_idle("case4");
    check("stall_seen", stall_armed, 0);
    rdy_mode = 0;
    send_px(1, 1, 20, 2, 3, 12, 0);
    n = 0;
    while (!(m_vld && m_tile_x == 1 && m_tile_y == 0) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("reach_tile10", n, 0);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_m_vld", m_vld, 0);
    check("mid_rst_s_rdy", s_rdy, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_counters", {tiles_issued, tris_culled}, 0);
    send_px(1, 1, 20, 2, 3, 12, 0);
    wait_idle("case5");
    send_px(9, 9, 10, 9, 9, 10, 1);
    send_px(1, 1, 20, 2, 3, 12, 0);
    wait_idle("case6");
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      c = $urandom_range(0, 170) - 20;
      h = $urandom_range(0, 30);
      for (int k = 0; k < 6; k++)
        v[k] = (c + $urandom_range(0, 2 * h) - h) * 16 + $urandom_range(0, 15);
      if (t % 7 == 3) v[1] = v[1] - 3200;
      send(v[0], v[1], v[2], v[3], v[4], v[5], $urandom_range(0, 1) == 1);
      if (t % 5 == 4) wait_idle("rand");
    end
    s_vld = 0;
    wait_idle("rand_end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
